// File: rtl/digital_diff_n_if.sv
// Sample-in / difference-out stream bundle for digital_diff_n.
// The master side feeds samples and accepts results; the slave side is the differencer.
interface digital_diff_n_if #(
    parameter int WIDTH = 8
);
    logic signed [WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_ovf;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ovf
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ovf
    );
endinterface

// File: rtl/digital_diff_n.sv
// Lag-N differencer: out = x[n] - x[n-LAG] over accepted samples, one-cycle latency.
// DIGITAL_DIFF_SAT_EN selects saturating output; otherwise the result wraps.
module digital_diff_n #(
    parameter int WIDTH = 8,
    parameter int LAG   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    digital_diff_n_if.slave  s,
    output logic             warm
);
    localparam int              CNT_W    = $clog2(LAG + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAG);

    logic signed [WIDTH-1:0] hist_p0 [LAG];
    logic [CNT_W-1:0]        cnt_p0;
    logic signed [WIDTH-1:0] data_p1;
    logic                    ovf_p1;
    logic                    vld_p1;
    logic                    accept;
    logic signed [WIDTH:0]   diff;

    // The extra bit holds the exact difference; a mismatch between the top two bits means it does not fit.
    function automatic logic diff_ovf(input logic signed [WIDTH:0] d);
        return d[WIDTH] != d[WIDTH-1];
    endfunction

    function automatic logic signed [WIDTH-1:0] diff_fit(input logic signed [WIDTH:0] d);
`ifdef DIGITAL_DIFF_SAT_EN
        if (diff_ovf(d))
            return d[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return d[WIDTH-1:0];
`else
        return d[WIDTH-1:0];
`endif
    endfunction

    assign s.in_ready = !clr && (!vld_p1 || s.out_ready);
    assign accept     = s.in_valid && s.in_ready;
    assign warm       = (cnt_p0 == CNT_FULL);
    assign diff       = $signed({s.in_data[WIDTH-1], s.in_data})
                      - $signed({hist_p0[LAG-1][WIDTH-1], hist_p0[LAG-1]});

    // Stage p0: history shift register and warm-up counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAG; i++) hist_p0[i] <= '0;
            cnt_p0 <= '0;
        end else if (clr) begin
            for (int i = 0; i < LAG; i++) hist_p0[i] <= '0;
            cnt_p0 <= '0;
        end else if (accept) begin
            for (int i = LAG - 1; i > 0; i--) hist_p0[i] <= hist_p0[i-1];
            hist_p0[0] <= s.in_data;
            if (!warm) cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
    end

    // Stage p1: registered difference with output handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_p1 <= '0;
            ovf_p1  <= 1'b0;
            vld_p1  <= 1'b0;
        end else if (clr) begin
            vld_p1  <= 1'b0;
        end else if (accept && warm) begin
            data_p1 <= diff_fit(diff);
            ovf_p1  <= diff_ovf(diff);
            vld_p1  <= 1'b1;
        end else if (s.out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign s.out_data  = data_p1;
    assign s.out_ovf   = ovf_p1;
    assign s.out_valid = vld_p1;
endmodule
